// File: rtl/demux_lane_sched_pkg.sv
// Shared types for the receive-nibble lane scheduler: FSM states, lane index
// and the lane a fresh configuration starts from.
package demux_sched_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int NUM_LANES  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef logic lane_idx_t;

    // Lane 0 gets the first word when it is enabled; otherwise start on lane 1.
    function automatic lane_idx_t first_lane(input logic [NUM_LANES-1:0] en);
        return en[0] ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/demux_lane_sched_lane_fifo.sv
// Per-lane holding FIFO. Full and empty come from the registered count; a push
// into a full FIFO is dropped, so a same-cycle pop never frees a slot early.
module lane_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_lane_sched.sv
// Round-robin steering of the receive nibble stream onto two lane FIFOs, with a
// drain phase around enable changes. DEMUX_LANE_SCHED_STATS_EN adds cnt0/cnt1.
module demux_lane_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    input  logic [1:0]        lane_en,
    input  logic              ready0,
    input  logic              ready1,
    output logic              validout0,
    output logic              validout1,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1,
    output logic              busy
`ifdef DEMUX_LANE_SCHED_STATS_EN
    ,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
`endif
);

    sched_state_e           state_q, state_d;
    lane_idx_t              sel_q, sel_d;
    logic [NUM_LANES-1:0]   lane_en_q, lane_en_d;

    logic [NUM_LANES-1:0]   fifo_push;
    logic [NUM_LANES-1:0]   fifo_pop;
    logic [NUM_LANES-1:0]   fifo_empty;
    logic [NUM_LANES-1:0]   fifo_full;
    logic [NUM_LANES-1:0]   lane_ready;
    logic [NUM_LANES-1:0]   lane_open;
    logic [DATA_W-1:0]      fifo_head [NUM_LANES];
    logic                   accept;
    lane_idx_t              target;

    assign lane_ready = {ready1, ready0};
    assign lane_open  = lane_en_q & ~fifo_full;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign fifo_pop[gi] = !fifo_empty[gi] && lane_ready[gi];

            lane_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk_4f (clk_4f),
                .reset  (reset),
                .push   (fifo_push[gi]),
                .pop    (fifo_pop[gi]),
                .din    (data_in),
                .head   (fifo_head[gi]),
                .empty  (fifo_empty[gi]),
                .full   (fifo_full[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        lane_en_d = lane_en_q;
        ready_in  = 1'b0;
        accept    = 1'b0;
        fifo_push = '0;
        target    = sel_q;
        case (state_q)
            IDLE: begin
                if (lane_en != '0) begin
                    lane_en_d = lane_en;
                    sel_d     = first_lane(lane_en);
                    state_d   = RUN;
                end
            end
            RUN: begin
                ready_in = |lane_open;
                accept   = valid_in && ready_in;
                // Fall over to the other lane when the preferred one cannot take the word.
                target   = lane_open[sel_q] ? sel_q : ~sel_q;
                if (accept) begin
                    fifo_push[target] = 1'b1;
                    sel_d             = ~target;
                end
                if (lane_en != lane_en_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (&fifo_empty) begin
                    lane_en_d = lane_en;
                    sel_d     = first_lane(lane_en);
                    state_d   = (lane_en != '0) ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            lane_en_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lane_en_q <= lane_en_d;
        end
    end

    assign validout0 = !fifo_empty[0];
    assign validout1 = !fifo_empty[1];
    assign dataout0  = fifo_head[0];
    assign dataout1  = fifo_head[1];
    assign busy      = (state_q != IDLE);

`ifdef DEMUX_LANE_SCHED_STATS_EN
    logic [15:0] cnt_q [NUM_LANES];
    logic [15:0] cnt_d [NUM_LANES];

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (fifo_push[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_lane_sched.sv
// Bench for demux_lane_sched: queue-based lane model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_demux_lane_sched;

    localparam int DW    = 4;
    localparam int DEPTH = 2;

    logic          clk_4f = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_in;
    logic [1:0]    lane_en;
    logic          ready0, ready1;
    logic          validout0, validout1;
    logic [DW-1:0] dataout0, dataout1;
    logic          busy;
`ifdef DEMUX_LANE_SCHED_STATS_EN
    logic [15:0]   cnt0, cnt1;
`endif

    demux_lane_sched #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .lane_en   (lane_en),
        .ready0    (ready0),
        .ready1    (ready1),
        .validout0 (validout0),
        .validout1 (validout1),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .busy      (busy)
`ifdef DEMUX_LANE_SCHED_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 drain; lanes are plain queues.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            m_mode = 0;
    int            m_sel  = 0;
    logic [1:0]    m_en   = 2'b00;
    bit            m_live = 0;
    int            m_cnt0 = 0;
    int            m_cnt1 = 0;

    logic [DW-1:0] obs0[$];
    logic [DW-1:0] obs1[$];

    function automatic bit exp_ready();
        if (m_mode != 1) return 1'b0;
        return (m_en[0] && q0.size() < DEPTH) || (m_en[1] && q1.size() < DEPTH);
    endfunction

    always @(posedge clk_4f) begin
        bit rdy, acc, pre_empty;
        int tgt, s0, s1, ssel;
        if (reset) begin
            q0.delete();
            q1.delete();
            m_mode = 0;
            m_sel  = 0;
            m_en   = 2'b00;
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_live = 1;
        end else if (m_live) begin
            rdy       = exp_ready();
            acc       = valid_in && rdy;
            s0        = q0.size();
            s1        = q1.size();
            pre_empty = (s0 == 0) && (s1 == 0);
            ssel      = (m_sel == 0) ? s0 : s1;
            tgt       = (m_en[m_sel] && ssel < DEPTH) ? m_sel : 1 - m_sel;
            if (s0 > 0 && ready0) void'(q0.pop_front());
            if (s1 > 0 && ready1) void'(q1.pop_front());
            if (acc) begin
                if (tgt == 0) begin
                    q0.push_back(data_in);
                    if (m_cnt0 < 65535) m_cnt0++;
                end else begin
                    q1.push_back(data_in);
                    if (m_cnt1 < 65535) m_cnt1++;
                end
                m_sel = 1 - tgt;
            end
            case (m_mode)
                0: if (lane_en != 2'b00) begin
                    m_en   = lane_en;
                    m_sel  = lane_en[0] ? 0 : 1;
                    m_mode = 1;
                end
                1: if (lane_en != m_en) m_mode = 2;
                default: if (pre_empty) begin
                    m_en   = lane_en;
                    m_sel  = lane_en[0] ? 0 : 1;
                    m_mode = (lane_en != 2'b00) ? 1 : 0;
                end
            endcase
        end
    end

    always @(negedge clk_4f) begin
        if (m_live) begin
            chk("ready_in", int'(ready_in), int'(exp_ready()));
            chk("validout0", int'(validout0), int'(q0.size() > 0));
            chk("validout1", int'(validout1), int'(q1.size() > 0));
            chk("dataout0", int'(dataout0), (q0.size() > 0) ? int'(q0[0]) : 0);
            chk("dataout1", int'(dataout1), (q1.size() > 0) ? int'(q1[0]) : 0);
            chk("busy", int'(busy), int'(m_mode != 0));
`ifdef DEMUX_LANE_SCHED_STATS_EN
            chk("cnt0", int'(cnt0), m_cnt0);
            chk("cnt1", int'(cnt1), m_cnt1);
`endif
            if (validout0 && ready0) obs0.push_back(dataout0);
            if (validout1 && ready1) obs1.push_back(dataout1);
        end
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        int accepts;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        lane_en  = 2'b00;
        ready0   = 1'b0;
        ready1   = 1'b0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready_in", int'(ready_in), 0);
        reset = 1'b0;

        // Alternating steering with both consumers ready
        lane_en = 2'b11;
        ready0  = 1'b1;
        ready1  = 1'b1;
        step();
        chk("s1_busy", int'(busy), 1);
        valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_in = DW'(i);
            step();
            if (i % 2 == 1) chk("s1_lat_d0", int'(dataout0), i);
            else            chk("s1_lat_d1", int'(dataout1), i);
        end
        valid_in = 1'b0;
        step();
        step();
        chk("s1_l0_n", obs0.size(), 2);
        chk("s1_l1_n", obs1.size(), 2);
        if (obs0.size() == 2 && obs1.size() == 2) begin
            chk("s1_l0_w0", int'(obs0[0]), 1);
            chk("s1_l0_w1", int'(obs0[1]), 3);
            chk("s1_l1_w0", int'(obs1[0]), 2);
            chk("s1_l1_w1", int'(obs1[1]), 4);
        end

        // Lane 0 stalled: overflow spills to lane 1
        obs0.delete();
        obs1.delete();
        ready0   = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DW'(10 + i);
            chk("s2_ready_in", int'(ready_in), 1);
            step();
        end
        valid_in = 1'b0;
        step();
        step();
        chk("s2_l0_head", int'(dataout0), 10);
        chk("s2_l1_n", obs1.size(), 3);
        if (obs1.size() == 3) chk("s2_l1_last", int'(obs1[2]), 14);
        ready0 = 1'b1;
        repeat (3) step();
        chk("s2_l0_n", obs0.size(), 2);

        // Both consumers stalled: four accepts then back-pressure
        ready0   = 1'b0;
        ready1   = 1'b0;
        accepts  = 0;
        valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = DW'(i);
            if (ready_in) accepts++;
            step();
        end
        chk("s3_accepts", accepts, 4);
        chk("s3_ready_low", int'(ready_in), 0);
        valid_in = 1'b0;
        ready0   = 1'b1;
        step();
        chk("s3_ready_back", int'(ready_in), 1);
        ready1 = 1'b1;
        repeat (3) step();

        // Reconfigure to lane 0 only while lane 1 holds two words
        ready0   = 1'b1;
        ready1   = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = DW'(i + 5);
            step();
        end
        valid_in = 1'b0;
        chk("s4_l1_held", int'(validout1), 1);
        lane_en = 2'b01;
        step();
        chk("s4_drain_busy", int'(busy), 1);
        chk("s4_drain_rdy", int'(ready_in), 0);
        step();
        step();
        chk("s4_drain_rdy2", int'(ready_in), 0);
        ready1 = 1'b1;
        repeat (3) step();
        chk("s4_run_rdy", int'(ready_in), 1);
        obs0.delete();
        obs1.delete();
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = DW'(i + 1);
            step();
        end
        valid_in = 1'b0;
        step();
        chk("s4_l0_n", obs0.size(), 4);
        chk("s4_l1_n", obs1.size(), 0);

        // Reset with data in both lanes
        lane_en = 2'b11;
        step();
        step();
        ready0   = 1'b0;
        ready1   = 1'b0;
        valid_in = 1'b1;
        data_in  = 4'h9;
        step();
        data_in  = 4'h6;
        step();
        valid_in = 1'b0;
        chk("s5_v0", int'(validout0), 1);
        chk("s5_v1", int'(validout1), 1);
        reset = 1'b1;
        step();
        chk("s5_rst_v0", int'(validout0), 0);
        chk("s5_rst_v1", int'(validout1), 0);
        chk("s5_rst_d0", int'(dataout0), 0);
        chk("s5_rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Three words after reset: two to lane 0, one to lane 1
        ready0 = 1'b1;
        ready1 = 1'b1;
        step();
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = DW'(i + 2);
            step();
        end
        valid_in = 1'b0;
        step();
`ifdef DEMUX_LANE_SCHED_STATS_EN
        chk("stats_cnt0", int'(cnt0), 2);
        chk("stats_cnt1", int'(cnt1), 1);
`endif

        // Randomized traffic, enable changes and occasional reset
        for (int c = 0; c < 3000; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = DW'($urandom);
            ready0   = ($urandom_range(0, 2) != 0);
            ready1   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) lane_en = 2'($urandom);
            reset    = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
